regs_file_mp: RTL and testbench



---
 rtl/regs_file_mp_pkg.sv | 21 ++
 rtl/regs_file_mp_rd_port.sv | 46 ++++
 rtl/regs_file_mp.sv | 133 +++++++++++++
 tb/tb_regs_file_mp.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/regs_file_mp_pkg.sv
// ============================================================================
// Module   : regs_file_mp_pkg
// Purpose  : Shared widths and state encodings for the multi-port register file.
//            Optional build switch: REGS_FILE_MP_FWD_EN (used by regs_file_rd_port).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package regs_file_mp_pkg;

  localparam int CPU_WIDTH      = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic [0:0] {
    REGS_ST_CLEAR = 1'b0,
    REGS_ST_RUN   = 1'b1
  } regs_state_e;

endpackage

`default_nettype wire

// File: rtl/regs_file_mp_rd_port.sv
// ============================================================================
// Module   : regs_file_rd_port
// Purpose  : One combinational read port with x0 / clear-sweep masking.
//            Define REGS_FILE_MP_FWD_EN to enable write-through bypass.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regs_file_rd_port #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clearing_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [XLEN-1:0]   stored_i,
  input  logic              wr_fire_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [XLEN-1:0]   wr_data_i,
  output logic [XLEN-1:0]   rd_data_o
);

`ifdef REGS_FILE_MP_FWD_EN
  // wr_fire_i is only ever high in RUN with a nonzero address
  always_comb begin
    rd_data_o = stored_i;
    if (clearing_i || (rd_addr_i == '0)) begin
      rd_data_o = '0;
    end else if (wr_fire_i && (wr_addr_i == rd_addr_i)) begin
      rd_data_o = wr_data_i;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = &{1'b0, wr_fire_i, wr_addr_i, wr_data_i};

  always_comb begin
    rd_data_o = stored_i;
    if (clearing_i || (rd_addr_i == '0)) begin
      rd_data_o = '0;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/regs_file_mp.sv
// ============================================================================
// Module   : regs_file_mp
// Purpose  : Parametrised multi-read-port register file with clear sweep,
//            ready flag, write-drop pulse and bit-0 taps.
//            Optional build switch: REGS_FILE_MP_FWD_EN (write-through bypass).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regs_file_mp
  import regs_file_mp_pkg::*;
#(
  parameter int XLEN     = CPU_WIDTH,
  parameter int ADDR_W   = REG_ADDR_WIDTH,
  parameter int NUM_RD   = 2,
  parameter int TAP_BASE = 26,
  parameter int NUM_TAPS = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_req_i,
  output logic                     ready_o,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [XLEN-1:0]          wr_data_i,
  output logic                     wr_drop_o,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*XLEN-1:0]   rd_data_o,
  output logic [NUM_TAPS-1:0]      tap_o
);

  localparam int DEPTH = 1 << ADDR_W;

  regs_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              wr_drop_q, wr_drop_d;
  logic [XLEN-1:0]   regs_q [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [XLEN-1:0]   mem_wdata;
  logic              wr_fire;
  logic              in_clear;

  assign in_clear = (state_q == REGS_ST_CLEAR);
  assign wr_fire  = (state_q == REGS_ST_RUN) && wr_en_i && (wr_addr_i != '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_d   = ready_q;
    wr_drop_d = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = wr_addr_i;
    mem_wdata = wr_data_i;
    unique case (state_q)
      REGS_ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + ADDR_W'(1);
        wr_drop_d = wr_en_i && (wr_addr_i != '0);
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = REGS_ST_RUN;
          ready_d = 1'b1;
        end
      end
      REGS_ST_RUN: begin
        // The write of a clear-request cycle still lands; the sweep wipes it later
        mem_we = wr_fire;
        if (clr_req_i) begin
          state_d = REGS_ST_CLEAR;
          cnt_d   = ADDR_W'(1);
          ready_d = 1'b0;
        end
      end
      default: begin
        state_d = REGS_ST_CLEAR;
        cnt_d   = ADDR_W'(1);
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= REGS_ST_CLEAR;
      cnt_q     <= ADDR_W'(1);
      ready_q   <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      regs_q[mem_waddr] <= mem_wdata;
    end
  end

  assign ready_o   = ready_q;
  assign wr_drop_o = wr_drop_q;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] port_addr;
    assign port_addr = rd_addr_i[p*ADDR_W +: ADDR_W];

    regs_file_rd_port #(
      .XLEN   (XLEN),
      .ADDR_W (ADDR_W)
    ) u_port (
      .clearing_i (in_clear),
      .rd_addr_i  (port_addr),
      .stored_i   (regs_q[port_addr]),
      .wr_fire_i  (wr_fire),
      .wr_addr_i  (wr_addr_i),
      .wr_data_i  (wr_data_i),
      .rd_data_o  (rd_data_o[p*XLEN +: XLEN])
    );
  end

  for (genvar i = 0; i < NUM_TAPS; i++) begin : g_tap
    assign tap_o[i] = regs_q[TAP_BASE + i][0];
  end

endmodule

`default_nettype wire

// File: tb/tb_regs_file_mp.sv
// ============================================================================
// Module   : tb_regs_file_mp
// Purpose  : Directed self-checking bench for regs_file_mp (default params).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regs_file_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_req;
  logic        ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_drop;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  tap;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regs_file_mp dut (
    .clk       (clk),
    .rst       (rst),
    .clr_req_i (clr_req),
    .ready_o   (ready),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .wr_drop_o (wr_drop),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data),
    .tap_o     (tap)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  etap;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  logic [31:0] bypass_exp;
  int          bad;
  int          n;

  initial begin
`ifdef REGS_FILE_MP_FWD_EN
    bypass_exp = 32'hA5A5_A5A5;
`else
    bypass_exp = 32'h0;
`endif
    vecs[0] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 5'd0,  5'd0,  32'h0,         32'h0,         2'b00};
    vecs[1] = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b00};
    vecs[2] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd5,  5'd0,  32'hDEAD_BEEF, 32'h0,         2'b00};
    vecs[3] = '{1'b1, 5'd26, 32'h1,         5'd0,  5'd0,  32'h0,         32'h0,         2'b00};
    vecs[4] = '{1'b1, 5'd27, 32'h3,         5'd26, 5'd5,  32'h1,         32'hDEAD_BEEF, 2'b01};
    vecs[5] = '{1'b0, 5'd0,  32'h0,         5'd27, 5'd26, 32'h3,         32'h1,         2'b11};
    vecs[6] = '{1'b1, 5'd3,  32'hA5A5_A5A5, 5'd5,  5'd3,  32'hDEAD_BEEF, bypass_exp,    2'b11};
    vecs[7] = '{1'b1, 5'd26, 32'h0,         5'd3,  5'd3,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 2'b11};

    rst = 1'b1; clr_req = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    repeat (3) tick();
    chk("reset_ready", 64'(ready), 64'h0);
    chk("reset_drop", 64'(wr_drop), 64'h0);
    set_rd(5'd1, 5'd31);
    #1;
    chk("reset_rd", rd_data, 64'h0);

    // Reset-release sweep: ready low before edges 1..31, high in cycle 32
    rst = 1'b0;
    bad = 0;
    for (int k = 1; k <= 31; k++) begin
      if (ready !== 1'b0) bad++;
      tick();
    end
    chk("sweep_ready_low", 64'(bad), 64'h0);
    chk("sweep_ready_high", 64'(ready), 64'h1);
    for (int a = 1; a < 32; a++) begin
      set_rd(5'(a), 5'(a));
      #1;
      chk("post_sweep_zero", rd_data, 64'h0);
    end
    chk("post_sweep_tap", 64'(tap), 64'h0);

    // Table of RUN-state vectors; expectations are for the cycle before the edge
    for (int i = 0; i < 8; i++) begin
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      set_rd(vecs[i].ra0, vecs[i].ra1);
      #1;
      chk($sformatf("vec%0d_rd0", i), 64'(rd_data[31:0]), 64'(vecs[i].e0));
      chk($sformatf("vec%0d_rd1", i), 64'(rd_data[63:32]), 64'(vecs[i].e1));
      chk($sformatf("vec%0d_tap", i), 64'(tap), 64'(vecs[i].etap));
      chk($sformatf("vec%0d_drop", i), 64'(wr_drop), 64'h0);
      tick();
    end

    // Clear request with a same-cycle write to x26 (observable on tap_o[0])
    wr_en = 1'b1; wr_addr = 5'd26; wr_data = 32'h13; clr_req = 1'b1;
    set_rd(5'd5, 5'd5);
    #1;
    chk("clr_pre_rd", 64'(rd_data[31:0]), 64'hDEAD_BEEF);
    chk("clr_pre_tap", 64'(tap), 64'b10);
    tick();
    chk("clr_ready_low", 64'(ready), 64'h0);
    chk("clr_rd_masked", rd_data, 64'h0);
    chk("clr_write_done", 64'(tap), 64'b11);
    wr_addr = 5'd9; wr_data = 32'h55;
    tick();
    chk("drop_pulse", 64'(wr_drop), 64'h1);
    wr_en = 1'b0;
    tick();
    chk("drop_single", 64'(wr_drop), 64'h0);
    // clr_req stays high throughout this sweep and must not extend it
    n = 2;
    while (ready !== 1'b1 && n < 40) begin
      if (n == 25) chk("tap_before_sweep", 64'(tap), 64'b11);
      if (n == 26) chk("tap_after_x26", 64'(tap), 64'b10);
      tick();
      n++;
    end
    chk("clr_sweep_len", 64'(n), 64'd31);
    clr_req = 1'b0;
    set_rd(5'd9, 5'd26);
    #1;
    chk("clr_wiped", rd_data, 64'h0);
    chk("clr_tap_zero", 64'(tap), 64'b00);

    // Reset during sweep cycle 10 restarts at x1
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h77;
    tick();
    wr_en = 1'b0; clr_req = 1'b1;
    set_rd(5'd2, 5'd0);
    #1;
    chk("x2_written", 64'(rd_data[31:0]), 64'h77);
    tick();
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_ready", 64'(ready), 64'h0);
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("rst_sweep_len", 64'(n), 64'd31);
    clr_req = 1'b0;
    #1;
    chk("rst_x2_zero", rd_data, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
